// File: rtl/hex_word_ascii_serializer.sv
// -----------------------------------------------------------------------------
// hex_word_ascii_serializer
//
// Accepts a NIBBLES-wide hexadecimal word over a valid/ready handshake and
// emits its ASCII digit characters one per output handshake, most significant
// nibble first. Case (upper) and leading-zero suppression (suppress_zeros) are
// sampled together with the word.
//
// Optional feature macro: HEX_ASCII_PREFIX_EN
//   defined   : every word is preceded by the characters '0' and 'x'
//   undefined : digits only
//
// Parameters
//   NIBBLES         hex digits per input word (1..16)
//
// Ports
//   clk             system clock, rising edge
//   clrn            asynchronous active-low reset
//   in_valid        in_data/upper/suppress_zeros valid
//   in_ready        block can accept a word (only in IDLE)
//   in_data         word to convert, 4*NIBBLES bits
//   upper           1: a-f as 'A'-'F', 0: 'a'-'f'
//   suppress_zeros  1: drop leading zero nibbles (at least one digit remains)
//   out_valid       out_ascii holds a character
//   out_ready       sink accepts the character
//   out_ascii       ASCII character (registered)
//   out_last        high with the final character of the word (registered)
// -----------------------------------------------------------------------------
module hex_word_ascii_serializer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_data,
    input  logic                   upper,
    input  logic                   suppress_zeros,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_ascii,
    output logic                   out_last
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
`ifdef HEX_ASCII_PREFIX_EN
        PREFIX0 = 2'd1,
        PREFIX1 = 2'd2,
`endif
        DIGIT   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [4*NIBBLES-1:0]   word_q, word_d;
    logic                   upper_q, upper_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_ascii_q, out_ascii_d;
    logic                   out_last_q, out_last_d;

    // Nibble at a run-time index, built as an explicit mux over the
    // legal indices so no out-of-range select is ever formed.
    function automatic logic [3:0] nib_at(input logic [4*NIBBLES-1:0] word,
                                          input logic [IDX_W-1:0]     idx);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) r = word[i*4 +: 4];
        end
        return r;
    endfunction

    // Index of the first nibble to emit. With suppression the ascending
    // scan leaves the highest non-zero nibble; an all-zero word keeps 0.
    function automatic logic [IDX_W-1:0] first_index(input logic [4*NIBBLES-1:0] word,
                                                     input logic                 sup);
        logic [IDX_W-1:0] r;
        r = IDX_W'(NIBBLES - 1);
        if (sup) begin
            r = '0;
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (word[i*4 +: 4] != 4'h0) r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // 0-9 -> '0'-'9'; 10-15 -> 'A'-'F' (0x41-10 = 0x37) or 'a'-'f' (0x61-10 = 0x57).
    function automatic logic [7:0] hex_char(input logic [3:0] nib, input logic up);
        logic [7:0] r;
        if (nib < 4'd10)
            r = 8'h30 + {4'h0, nib};
        else if (up)
            r = 8'h37 + {4'h0, nib};
        else
            r = 8'h57 + {4'h0, nib};
        return r;
    endfunction

    // Next-state and next-output logic. Output registers are loaded with the
    // character that will be presented in the following cycle, so out_ascii,
    // out_valid and out_last never depend combinationally on out_ready.
    always_comb begin
        logic [IDX_W-1:0] start_idx;
        logic [IDX_W-1:0] next_idx;

        state_d     = state_q;
        word_d      = word_q;
        upper_d     = upper_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_ascii_d = out_ascii_q;
        out_last_d  = out_last_q;
        start_idx   = first_index(in_data, suppress_zeros);
        next_idx    = idx_q - IDX_W'(1);

        unique case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (in_valid) begin
                    word_d      = in_data;
                    upper_d     = upper;
                    idx_d       = start_idx;
                    out_valid_d = 1'b1;
`ifdef HEX_ASCII_PREFIX_EN
                    state_d     = PREFIX0;
                    out_ascii_d = 8'h30;
                    out_last_d  = 1'b0;
`else
                    state_d     = DIGIT;
                    out_ascii_d = hex_char(nib_at(in_data, start_idx), upper);
                    out_last_d  = (start_idx == '0);
`endif
                end
            end

`ifdef HEX_ASCII_PREFIX_EN
            PREFIX0: begin
                if (out_ready) begin
                    state_d     = PREFIX1;
                    out_ascii_d = 8'h78;
                    out_last_d  = 1'b0;
                end
            end

            PREFIX1: begin
                if (out_ready) begin
                    state_d     = DIGIT;
                    out_ascii_d = hex_char(nib_at(word_q, idx_q), upper_q);
                    out_last_d  = (idx_q == '0);
                end
            end
`endif

            DIGIT: begin
                if (out_ready) begin
                    if (idx_q == '0) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        idx_d       = next_idx;
                        out_ascii_d = hex_char(nib_at(word_q, next_idx), upper_q);
                        out_last_d  = (next_idx == '0);
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            word_q      <= '0;
            upper_q     <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_ascii_q <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            upper_q     <= upper_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_ascii_q <= out_ascii_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_ascii = out_ascii_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/hex_word_ascii_serializer.md
# hex_word_ascii_serializer

Streaming converter that accepts a NIBBLES-wide hexadecimal word over a valid/ready handshake and emits its ASCII digit characters one per handshake, most significant nibble first. It supports run-time upper/lower case and leading-zero suppression. It sits between scan-code/register sources and the PS/2 display text buffer, replacing per-nibble combinational lookups with a single backpressured character stream.

## Interface
- NIBBLES, default 4: hex digits per input word; legal range 1..16.
- clk  input  1  system clock; all state updates on rising edge.
- clrn  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/upper/suppress_zeros are valid.
- in_ready  output  1  block can accept a word.
- in_data  input  4*NIBBLES  word to convert.
- upper  input  1  1: digits a–f emitted as 0x41–0x46; 0: 0x61–0x66. Sampled at accept.
- suppress_zeros  input  1  1: drop leading zero nibbles. Sampled at accept.
- out_valid  output  1  out_ascii holds a character.
- out_ready  input  1  sink accepts the character.
- out_ascii  output  8  ASCII character.
- out_last  output  1  high with the final character of the word.

## Operation
- States: IDLE, PREFIX0, PREFIX1, DIGIT. PREFIX states exist only with the macro in Configuration.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: latch in_data, upper; compute start index; go to PREFIX0 (macro on) or DIGIT (macro off).
- Start index: NIBBLES-1, or with suppress_zeros=1 the index of the highest non-zero nibble; an all-zero word starts at index 0, so exactly one '0' (0x30) is emitted. A word is never empty.
- DIGIT: out_ascii = mapping of nibble[idx]: 0–9 -> 0x30–0x39; a–f -> 0x61–0x66, or 0x41–0x46 if latched upper=1. out_last = (idx==0). On out_valid&&out_ready: idx decrements; if idx was 0 go to IDLE.
- out_ascii/out_valid/out_last are registered and held stable while out_valid=1 and out_ready=0.
- in_ready=0 in every non-IDLE state; inputs are ignored there.
- Reset (clrn low, any state, including mid-word): immediately to IDLE, word discarded, no partial tail emitted afterwards.
- Reset values: in_ready=1, out_valid=0, out_ascii=8'h00, out_last=0, idx=0.

## Timing
- Accept at edge k -> first character valid after edge k (out_valid high in cycle k+1).
- With out_ready held high, one character per cycle; a K-character word occupies cycles k+1..k+K.
- Last handshake at edge m -> IDLE, in_ready=1 in cycle m+1; next word accepted at edge m+1 earliest, first character of it in cycle m+2. Throughput: K+1 cycles per word.
- out_ready is not required to be high when out_valid rises; there is no combinational path from out_ready to out_valid/out_ascii, or from in_valid to in_ready.

## Configuration
- HEX_ASCII_PREFIX_EN defined: each word is preceded by '0' (0x30, PREFIX0) then 'x' (0x78, PREFIX1), each a normal handshaked character with out_last=0; the prefix is always lowercase and unaffected by suppress_zeros. Latency to first digit grows by 2 characters; throughput K+3 cycles per word.
- Not defined: PREFIX states absent; accept goes straight to DIGIT; output is digits only.

## Test plan
- NIBBLES=4, in_data=16'h1A2F, upper=0, suppress=0, out_ready=1 -> 0x31,0x61,0x32,0x66 in consecutive cycles, out_last only on 0x66; in_ready high again the cycle after.
- Same word, upper=1 -> 0x31,0x41,0x32,0x46.
- in_data=16'h000C, suppress=1 -> single 0x63 with out_last=1; in_data=16'h0000, suppress=1 -> single 0x30 with out_last=1; 16'h0000, suppress=0 -> four 0x30.
- 16'hBEEF with out_ready toggled randomly -> sequence 0x62,0x65,0x65,0x66 unchanged, out_ascii stable while stalled, no drops or duplicates; in_valid pulses during stream ignored.
- clrn pulsed low after second character of 16'h1234 -> out_valid=0, out_ascii=0x00, in_ready=1 immediately; next word 16'h00AB streams fully with no residual '3'/'4'.
- HEX_ASCII_PREFIX_EN defined, 16'h00FF, suppress=1, upper=1 -> 0x30,0x78,0x46,0x46, out_last on final 0x46.
